// File: rtl/sub_pkg.sv
// ---------------------------------------------------------------------------
// sub_pkg
// Shared types and constants for the bit-serial subtractor.
//   sub_state_t   : control state of the serial subtractor
//   DEFAULT_WIDTH : default operand width (sum is one bit wider)
//   sub_cnt_w     : width of the step counter for a given operand width
// ---------------------------------------------------------------------------
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sub_state_t;

  localparam int DEFAULT_WIDTH = 9;

  // The counter has to hold every step index 0..WIDTH plus the value it
  // steps to on the final cycle, hence WIDTH+2 distinct values.
  function automatic int sub_cnt_w(input int width);
    return $clog2(width + 2);
  endfunction

endpackage

// File: rtl/fsub_cell.sv
// ---------------------------------------------------------------------------
// fsub_cell
// Combinational 1-bit full subtractor: computes s - bb - bin.
// Ports:
//   s    in  minuend bit
//   bb   in  subtrahend bit
//   bin  in  borrow in
//   d    out difference bit
//   bout out borrow out
// ---------------------------------------------------------------------------
module fsub_cell (
  input  logic s,
  input  logic bb,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = s ^ bb ^ bin;
  assign bout = (~s & bb) | (~s & bin) | (bb & bin);

endmodule

// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
// Bit-serial inverse of the WIDTH-bit adder: given the (WIDTH+1)-bit sum and
// the WIDTH-bit addend b it recovers a = sum - b, one bit per clock, LSB
// first, and flags results outside the WIDTH-bit unsigned operand range.
// An operation is accepted in IDLE, takes WIDTH+1 SHIFT cycles, and the
// result is held in DONE until the consumer takes it.
// Ports:
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   in_valid   in   sum/b valid
//   in_ready   out  block can accept an operation (high only in IDLE)
//   sum        in   minuend, WIDTH+1 bits
//   b          in   subtrahend, WIDTH bits
//   out_valid  out  result valid (high only in DONE)
//   out_ready  in   consumer accepts result
//   diff       out  low WIDTH bits of sum - b
//   underflow  out  sum < b
//   overflow   out  sum - b > 2^WIDTH - 1
// ---------------------------------------------------------------------------
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH:0]   sum,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             underflow,
  output logic             overflow
);

  localparam int              CNT_W     = sub_cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH);

  sub_state_t       state;
  sub_state_t       state_nxt;

  // Operand shift registers; b is zero-extended so both are WIDTH+1 bits.
  logic [WIDTH:0]   s_sr;
  logic [WIDTH:0]   b_sr;
  // Collects the low WIDTH difference bits; bit WIDTH of the result is only
  // needed on the final step, where it comes straight from the cell.
  logic [WIDTH-1:0] res_sr;
  logic             borrow;
  logic [CNT_W-1:0] cnt;

  logic             cell_d;
  logic             cell_bout;
  logic             accept;
  logic             last_step;

  assign accept    = in_valid & in_ready;
  assign last_step = (state == SHIFT) && (cnt == LAST_STEP);

  fsub_cell u_cell (
    .s    (s_sr[0]),
    .bb   (b_sr[0]),
    .bin  (borrow),
    .d    (cell_d),
    .bout (cell_bout)
  );

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = SHIFT;
      SHIFT:   if (last_step) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from the registered state only
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Serial datapath: load on accept, one full-subtractor step per SHIFT cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
    end else if (accept) begin
      s_sr   <= sum;
      b_sr   <= {1'b0, b};
      res_sr <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
    end else if (state == SHIFT) begin
      s_sr   <= s_sr >> 1;
      b_sr   <= b_sr >> 1;
      res_sr <= {cell_d, res_sr[WIDTH-1:1]};
      borrow <= cell_bout;
      cnt    <= cnt + 1'b1;
    end
  end

  // Result registers: written once on the final step and then frozen, so
  // they stay stable through DONE regardless of backpressure.
  // On the final step res_sr already holds all WIDTH low bits, cell_d is
  // result bit WIDTH and cell_bout is the final borrow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      diff      <= '0;
      underflow <= 1'b0;
      overflow  <= 1'b0;
    end else if (last_step) begin
      diff      <= res_sr;
      underflow <= cell_bout;
      overflow  <= cell_d & ~cell_bout;
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  localparam int W = 9;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W:0]   sum = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         underflow;
  logic         overflow;

  typedef struct packed {
    logic [W-1:0] diff;
    logic         uf;
    logic         ov;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   bp_mode = 0;   // 0: out_ready=1, 1: out_ready=0, 2: random

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum       (sum),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .underflow (underflow),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain integer subtraction and range test.
  function automatic exp_t ref_model(input int s, input int bv);
    exp_t e;
    int   d;
    d      = s - bv;
    e.uf   = (d < 0);
    e.ov   = (d > (1 << W) - 1);
    e.diff = W'(d);
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Backpressure driver
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (bp_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'b0;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: pops the scoreboard on every output transfer
  always @(negedge clk) begin
    exp_t e;
    check("ready_valid_exclusive", {31'b0, in_ready & out_valid}, 32'd0);
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_output: got diff=%0h with empty scoreboard, expected no output", diff);
      end else begin
        e = sb.pop_front();
        check("diff", {23'b0, diff}, {23'b0, e.diff});
        check("underflow", {31'b0, underflow}, {31'b0, e.uf});
        check("overflow", {31'b0, overflow}, {31'b0, e.ov});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int s, input int bv, input bit push, input exp_t e, output int acc);
    int guard;
    guard = 0;
    in_valid = 1'b1;
    sum = s[W:0];
    b = bv[W-1:0];
    while (!in_ready && guard < 100) begin
      tick(1);
      guard++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: in_ready got 0 expected 1");
      in_valid = 1'b0;
      acc = cyc;
      return;
    end
    @(posedge clk);
    if (push) sb.push_back(e);
    #1;
    acc = cyc;
    in_valid = 1'b0;
    sum = ($urandom_range(0, 1023));
    b = ($urandom_range(0, 511));
  endtask

  task automatic wait_valid(output int at);
    int g;
    g = 0;
    while (!out_valid && g < 200) begin
      tick(1);
      g++;
    end
    if (!out_valid) begin
      tests++;
      fails++;
      $display("FAIL wait_valid_timeout: out_valid got 0 expected 1");
    end
    at = cyc;
  endtask

  task automatic wait_transfer();
    int g;
    g = 0;
    while (out_valid && g < 200) begin
      tick(1);
      g++;
    end
    if (out_valid) begin
      tests++;
      fails++;
      $display("FAIL wait_transfer_timeout: out_valid got 1 expected 0");
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (sb.size() != 0 && g < 2000) begin
      tick(1);
      g++;
    end
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
    end
  endtask

  initial begin
    int   acc;
    int   at;
    int   a;
    int   bv;
    int   s;
    bit   seen;
    exp_t held;
    exp_t rt;

    // Reset state
    reset_n = 1'b0;
    tick(3);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_diff", {23'b0, diff}, 32'd0);
    check("rst_underflow", {31'b0, underflow}, 32'd0);
    check("rst_overflow", {31'b0, overflow}, 32'd0);
    reset_n = 1'b1;
    tick(1);

    // 1 - 1: latency and ready return
    bp_mode = 0;
    send(1, 1, 1'b1, ref_model(1, 1), acc);
    wait_valid(at);
    check("latency", at - acc, W + 1);
    wait_transfer();
    check("in_ready_after_transfer", {31'b0, in_ready}, 32'd1);

    // Largest in-range result, then the first overflowing one
    send(1022, 511, 1'b1, ref_model(1022, 511), acc);
    send(1023, 511, 1'b1, ref_model(1023, 511), acc);
    drain();

    // Underflow held under backpressure while new operands are offered
    bp_mode = 1;
    tick(1);
    send(5, 6, 1'b1, ref_model(5, 6), acc);
    wait_valid(at);
    held = '{diff: diff, uf: underflow, ov: overflow};
    check("uf_diff", {23'b0, diff}, 32'h1FF);
    check("uf_flag", {31'b0, underflow}, 32'd1);
    check("uf_ovflag", {31'b0, overflow}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      sum = ($urandom_range(0, 1023));
      b = ($urandom_range(0, 511));
      tick(1);
      check("bp_out_valid", {31'b0, out_valid}, 32'd1);
      check("bp_in_ready", {31'b0, in_ready}, 32'd0);
      check("bp_diff", {23'b0, diff}, {23'b0, held.diff});
      check("bp_flags", {30'b0, underflow, overflow}, {30'b0, held.uf, held.ov});
    end
    in_valid = 1'b0;
    bp_mode = 0;
    wait_transfer();
    check("bp_in_ready_after", {31'b0, in_ready}, 32'd1);
    drain();

    // Asynchronous reset during SHIFT step 4 aborts the operation
    send(300, 45, 1'b0, ref_model(300, 45), acc);
    tick(3);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("arst_out_valid", {31'b0, out_valid}, 32'd0);
    check("arst_diff", {23'b0, diff}, 32'd0);
    check("arst_flags", {30'b0, underflow, overflow}, 32'd0);
    check("arst_in_ready", {31'b0, in_ready}, 32'd1);
    tick(2);
    reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 14; i++) begin
      tick(1);
      if (out_valid) seen = 1'b1;
    end
    check("arst_no_output", {31'b0, seen}, 32'd0);
    send(300, 45, 1'b1, ref_model(300, 45), acc);
    drain();
    check("post_rst_diff", {23'b0, diff}, 32'd255);

    // Round trip through the adder with random backpressure
    bp_mode = 2;
    for (int i = 0; i < 200; i++) begin
      a  = $urandom_range(0, (1 << W) - 1);
      bv = $urandom_range(0, (1 << W) - 1);
      rt = '{diff: a[W-1:0], uf: 1'b0, ov: 1'b0};
      send(a + bv, bv, 1'b1, rt, acc);
    end

    // Full-range sums exercising both flags
    for (int i = 0; i < 60; i++) begin
      s  = $urandom_range(0, (2 << W) - 1);
      bv = $urandom_range(0, (1 << W) - 1);
      send(s, bv, 1'b1, ref_model(s, bv), acc);
    end
    drain();
    bp_mode = 0;
    tick(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
